// File: rtl/mips_instr_encoder.sv
// Streaming MIPS encoder: symbolic op + fields in, addressed 32-bit word out.
// One-cycle latency; in_ready drops while the output is stalled, full, or in reset/restart.
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [15:0]                in_imm,
  input  logic [25:0]                in_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_addr,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       err,
  output logic [4:0]                 err_op
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [4:0] OP_ILLEGAL = 5'd31;

  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_addr_q, out_addr_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic [4:0]    err_op_q, err_op_d;

  logic [31:0]   enc_instr;
  logic          accept;
  logic          legal_acc;
  logic          illegal_acc;

  always_comb begin
    enc_instr = '0;
    case (in_op)
      5'd0:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
      5'd1:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100001};
      5'd2:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
      5'd3:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100011};
      5'd4:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
      5'd5:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
      5'd6:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100110};
      5'd7:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100111};
      5'd8:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
      5'd9:  enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101011};
      5'd10: enc_instr = {6'b000000, in_rs, 15'b0, 6'b001000};
      5'd11: enc_instr = {6'b000100, in_rs, in_rt, in_imm};
      5'd12: enc_instr = {6'b000101, in_rs, in_rt, in_imm};
      5'd13: enc_instr = {6'b001000, in_rs, in_rt, in_imm};
      5'd14: enc_instr = {6'b001001, in_rs, in_rt, in_imm};
      5'd15: enc_instr = {6'b001100, in_rs, in_rt, in_imm};
      5'd16: enc_instr = {6'b001111, 5'b0, in_rt, in_imm};
      5'd17: enc_instr = {6'b001101, in_rs, in_rt, in_imm};
      5'd18: enc_instr = {6'b001110, in_rs, in_rt, in_imm};
      5'd19: enc_instr = {6'b001010, in_rs, in_rt, in_imm};
      5'd20: enc_instr = {6'b001011, in_rs, in_rt, in_imm};
      5'd21: enc_instr = {6'b100011, in_rs, in_rt, in_imm};
      5'd22: enc_instr = {6'b100001, in_rs, in_rt, in_imm};
      5'd23: enc_instr = {6'b100101, in_rs, in_rt, in_imm};
      5'd24: enc_instr = {6'b100000, in_rs, in_rt, in_imm};
      5'd25: enc_instr = {6'b100100, in_rs, in_rt, in_imm};
      5'd26: enc_instr = {6'b101011, in_rs, in_rt, in_imm};
      5'd27: enc_instr = {6'b101001, in_rs, in_rt, in_imm};
      5'd28: enc_instr = {6'b101000, in_rs, in_rt, in_imm};
      5'd29: enc_instr = {6'b000010, in_target};
      5'd30: enc_instr = {6'b000011, in_target};
      default: enc_instr = '0;
    endcase
  end

  assign in_ready    = !rst && !restart && !full_q && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign legal_acc   = accept && (in_op != OP_ILLEGAL);
  assign illegal_acc = accept && (in_op == OP_ILLEGAL);

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    err_op_d    = err_op_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (legal_acc) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_addr_d  = BASE_ADDR + (32'(count_q) << 2);
      count_d     = count_q + CW'(1);
      full_d      = (count_d == CW'(DEPTH));
    end

    // Only the first illegal op is recorded until the flag is cleared.
    if (illegal_acc) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_op_d = in_op;
      end
    end

    if (restart) begin
      out_valid_d = 1'b0;
      count_d     = '0;
      full_d      = 1'b0;
      err_d       = 1'b0;
      err_op_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_op_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      err_op_q    <= err_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed spec vectors plus randomized traffic against a queue model.
module tb_mips_instr_encoder;

  localparam logic [31:0] A_BASE  = 32'h0040_0000;
  localparam int          A_DEPTH = 8;
  localparam int          A_CW    = $clog2(A_DEPTH) + 1;
  localparam logic [31:0] B_BASE  = 32'h0000_0100;
  localparam int          B_DEPTH = 2;
  localparam int          B_CW    = $clog2(B_DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: randomized + directed traffic
  logic            a_rst = 1'b1, a_restart = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [4:0]      a_in_op = '0, a_in_rs = '0, a_in_rt = '0, a_in_rd = '0;
  logic [15:0]     a_in_imm = '0;
  logic [25:0]     a_in_tgt = '0;
  logic            a_in_ready, a_out_valid, a_full, a_err;
  logic [31:0]     a_out_addr, a_out_instr;
  logic [A_CW-1:0] a_count;
  logic [4:0]      a_err_op;

  mips_instr_encoder #(.BASE_ADDR(A_BASE), .DEPTH(A_DEPTH)) dut_a (
    .clk(clk), .rst(a_rst), .restart(a_restart),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_rs(a_in_rs), .in_rt(a_in_rt), .in_rd(a_in_rd),
    .in_imm(a_in_imm), .in_target(a_in_tgt),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_addr(a_out_addr), .out_instr(a_out_instr),
    .count(a_count), .full(a_full), .err(a_err), .err_op(a_err_op)
  );

  // DUT B: small depth for the full boundary
  logic            b_rst = 1'b1, b_restart = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [4:0]      b_in_op = '0;
  logic            b_in_ready, b_out_valid, b_full, b_err;
  logic [31:0]     b_out_addr, b_out_instr;
  logic [B_CW-1:0] b_count;
  logic [4:0]      b_err_op;

  mips_instr_encoder #(.BASE_ADDR(B_BASE), .DEPTH(B_DEPTH)) dut_b (
    .clk(clk), .rst(b_rst), .restart(b_restart),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd3),
    .in_imm(16'h0007), .in_target(26'h0000000),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_addr(b_out_addr), .out_instr(b_out_instr),
    .count(b_count), .full(b_full), .err(b_err), .err_op(b_err_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Opcode / funct per op index 0..30 (entry 31 unused)
  bit [5:0] code_tab [32] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
    6'h08,
    6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0f, 6'h0d, 6'h0e, 6'h0a, 6'h0b,
    6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28,
    6'h02, 6'h03, 6'h00
  };

  function automatic logic [31:0] ref_enc(input logic [4:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    if (op <= 5'd9)  return {6'd0, rs, rt, rd, 5'd0, code_tab[op]};
    if (op == 5'd10) return {6'd0, rs, 15'd0, code_tab[op]};
    if (op <= 5'd28) return {code_tab[op], (op == 5'd16) ? 5'd0 : rs, rt, imm};
    return {code_tab[op], tgt};
  endfunction

  // Model of DUT A: pending words, count of legal accepts, sticky error
  logic [63:0] exp_q[$];
  int          m_count  = 0;
  logic        m_err    = 1'b0;
  logic [4:0]  m_err_op = '0;

  task automatic cyc_a(input logic vld, input logic [4:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic ordy, input logic rs_t,
                       input logic rst_t);
    logic exp_rdy;
    @(negedge clk);
    a_in_valid = vld; a_in_op = op; a_in_rs = rs; a_in_rt = rt; a_in_rd = rd;
    a_in_imm = imm; a_in_tgt = tgt; a_out_ready = ordy; a_restart = rs_t; a_rst = rst_t;
    #1;
    exp_rdy = !rst_t && !rs_t && (m_count != A_DEPTH) && (exp_q.size() == 0 || ordy);
    check("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    check("a_out_valid", 32'(a_out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("a_out_addr", a_out_addr, exp_q[0][63:32]);
      check("a_out_instr", a_out_instr, exp_q[0][31:0]);
    end
    check("a_count", 32'(a_count), 32'(m_count));
    check("a_full", 32'(a_full), 32'(m_count == A_DEPTH));
    check("a_err", 32'(a_err), 32'(m_err));
    check("a_err_op", 32'(a_err_op), 32'(m_err_op));
    if (rst_t || rs_t) begin
      exp_q.delete(); m_count = 0; m_err = 1'b0; m_err_op = '0;
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (vld && exp_rdy) begin
        if (op == 5'd31) begin
          if (!m_err) m_err_op = op;
          m_err = 1'b1;
        end else begin
          exp_q.push_back({A_BASE + 32'(m_count) * 4, ref_enc(op, rs, rt, rd, imm, tgt)});
          m_count++;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle_a(input logic ordy);
    cyc_a(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic restart_a();
    cyc_a(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic enc_test(input string tag, input logic [4:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic [31:0] exp);
    cyc_a(1'b1, op, rs, rt, rd, imm, tgt, 1'b1, 1'b0, 1'b0);
    #1;
    check(tag, a_out_instr, exp);
  endtask

  task automatic cyc_b(input logic vld, input logic [4:0] op, input logic rs_t);
    @(negedge clk);
    b_in_valid = vld; b_in_op = op; b_restart = rs_t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    b_rst = 1'b0;
    // Reset state
    cyc_a(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b0, 1'b1);
    #1;
    check("rst_out_addr", a_out_addr, 32'h0);
    check("rst_out_instr", a_out_instr, 32'h0);

    // Encoding sweep
    enc_test("enc_add",  5'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820);
    enc_test("enc_addi", 5'd13, 5'd0,  5'd8,  5'd9,  16'h0005, 26'h3ffffff, 32'h20080005);
    enc_test("enc_lw",   5'd21, 5'd29, 5'd31, 5'd7,  16'hfffc, 26'h0,       32'h8FBFFFFC);
    enc_test("enc_jr",   5'd10, 5'd31, 5'd9,  5'd9,  16'hffff, 26'h3ffffff, 32'h03E00008);
    enc_test("enc_j",    5'd29, 5'd7,  5'd7,  5'd7,  16'hffff, 26'h0000010, 32'h08000010);
    enc_test("enc_jal",  5'd30, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3ffffff, 32'h0FFFFFFF);
    enc_test("enc_lui",  5'd16, 5'd5,  5'd4,  5'd1,  16'h1234, 26'h0,       32'h3C041234);
    idle_a(1'b1);

    // Addressing, back-to-back
    restart_a();
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b1, 5'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
      #1;
      check("addr_seq", a_out_addr, A_BASE + 32'(i) * 4);
      check("addr_vld", 32'(a_out_valid), 32'd1);
    end
    check("addr_count", 32'(a_count), 32'd3);

    // Backpressure: four stalled cycles then release
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 5'd6, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 5'd7, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
    idle_a(1'b1);
    idle_a(1'b1);

    // Illegal op handling
    restart_a();
    cyc_a(1'b1, 5'd31, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1, 1'b1, 1'b0, 1'b0);
    cyc_a(1'b1, 5'd30, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3ffffff, 1'b1, 1'b0, 1'b0);
    #1;
    check("ill_jal_addr", a_out_addr, A_BASE);
    cyc_a(1'b1, 5'd31, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 1'b0, 1'b0);
    idle_a(1'b1);
    check("ill_err", 32'(a_err), 32'd1);
    check("ill_err_op", 32'(a_err_op), 32'd31);
    check("ill_count", 32'(a_count), 32'd1);

    // Restart / reset during a stall, restart with in_valid
    cyc_a(1'b1, 5'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 5'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b1, 1'b0);
    idle_a(1'b0);
    cyc_a(1'b1, 5'd5, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 5'd5, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 1'b0, 1'b1);
    idle_a(1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc_a(($urandom % 4) != 0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0, ($urandom % 200) == 0);
    end
    idle_a(1'b1);

    // Full boundary on DEPTH=2
    cyc_b(1'b1, 5'd13, 1'b0);
    check("b_first_addr", b_out_addr, B_BASE);
    check("b_first_full", 32'(b_full), 32'd0);
    cyc_b(1'b1, 5'd13, 1'b0);
    check("b_second_addr", b_out_addr, B_BASE + 32'd4);
    check("b_full", 32'(b_full), 32'd1);
    check("b_in_ready_full", 32'(b_in_ready), 32'd0);
    cyc_b(1'b1, 5'd13, 1'b0);
    check("b_count_held", 32'(b_count), 32'd2);
    check("b_drained", 32'(b_out_valid), 32'd0);
    check("b_still_full", 32'(b_full), 32'd1);
    cyc_b(1'b1, 5'd13, 1'b1);
    check("b_restart_count", 32'(b_count), 32'd0);
    check("b_restart_full", 32'(b_full), 32'd0);
    check("b_restart_vld", 32'(b_out_valid), 32'd0);
    cyc_b(1'b1, 5'd29, 1'b0);
    check("b_after_addr", b_out_addr, B_BASE);
    check("b_after_instr", b_out_instr, 32'h08000000);
    check("b_after_count", 32'(b_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
